bcd_display_scanner: RTL

- Downstream consumer of the mod10_counter count outputs.
- Takes NUM_DIGITS packed BCD digits, for example from cascaded mod-10 counters, and drives a time-multiplexed common-anode 7-segment display.
- Provides a refresh prescaler, a digit scan counter, per-slot ghosting guard, leading-zero blanking and tear-free frame-synchronous update of the displayed value.

---
 rtl/seg7_pkg.sv | 18 +
 rtl/bcd_to_seg7.sv | 27 ++
 rtl/bcd_display_scanner.sv | 135 +++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Seven-segment constants shared by the BCD encoder and the display scanner.
// Patterns are active-high in {g,f,e,d,c,b,a} order; polarity is applied at the top level only.
package seg7_pkg;
  localparam int DIGIT_W = 4;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;
endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-high 7-segment pattern.
// Nibbles 10..15 are not decimal digits and show a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [DIGIT_W-1:0] bcd,
  output logic [6:0]         seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 7-segment scanner with a guard cycle per slot and leading-zero blanking.
// New digits are staged in a pending register and only reach the display at a frame boundary.
module bcd_display_scanner
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS       = 4,
  parameter int REFRESH_DIV      = 4,
  parameter int SEG_ACTIVE_LOW   = 1,
  parameter int ANODE_ACTIVE_LOW = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DIGIT_W*NUM_DIGITS-1:0]   digits_in,
  input  logic                            valid,
  input  logic [NUM_DIGITS-1:0]           dp_in,
  input  logic                            blank_lz,
  output logic [6:0]                      seg,
  output logic                            dp,
  output logic [NUM_DIGITS-1:0]           anode,
  output logic [$clog2(NUM_DIGITS)-1:0]   digit_idx
);

  localparam int   IDX_W     = $clog2(NUM_DIGITS);
  localparam int   PRE_W     = $clog2(REFRESH_DIV);
  localparam int   DW        = DIGIT_W * NUM_DIGITS;
  localparam logic SEG_INV   = (SEG_ACTIVE_LOW != 0);
  localparam logic ANODE_INV = (ANODE_ACTIVE_LOW != 0);

  logic [PRE_W-1:0]      pre_q, pre_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DW-1:0]         disp_dig_q, disp_dig_d;
  logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
  logic [DW-1:0]         pend_dig_q, pend_dig_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic                  pend_flag_q, pend_flag_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [IDX_W-1:0]      digit_idx_q, digit_idx_d;

  logic                  tick, frame_end;
  logic [DIGIT_W-1:0]    cur_dig;
  logic                  cur_dp, cur_supp, zero_run;
  logic [6:0]            enc, seg_raw;
  logic [NUM_DIGITS-1:0] an_raw;

  always_comb begin
    tick      = (pre_q == PRE_W'(REFRESH_DIV - 1));
    frame_end = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));
    pre_d     = tick ? '0 : pre_q + PRE_W'(1);
    idx_d     = idx_q;
    if (tick) idx_d = frame_end ? '0 : idx_q + IDX_W'(1);

    pend_dig_d  = valid ? digits_in : pend_dig_q;
    pend_dp_d   = valid ? dp_in : pend_dp_q;
    pend_flag_d = valid || pend_flag_q;
    disp_dig_d  = disp_dig_q;
    disp_dp_d   = disp_dp_q;
    // A write landing on the boundary cycle bypasses pending so it is not a frame late.
    if (frame_end) begin
      pend_flag_d = 1'b0;
      if (valid) begin
        disp_dig_d = digits_in;
        disp_dp_d  = dp_in;
      end else if (pend_flag_q) begin
        disp_dig_d = pend_dig_q;
        disp_dp_d  = pend_dp_q;
      end
    end
  end

  // Walk from the most significant digit down so zero_run means "this and all above are 0".
  always_comb begin
    cur_dig  = '0;
    cur_dp   = 1'b0;
    cur_supp = 1'b0;
    zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run && (disp_dig_q[DIGIT_W*k +: DIGIT_W] == '0);
      if (idx_q == IDX_W'(k)) begin
        cur_dig  = disp_dig_q[DIGIT_W*k +: DIGIT_W];
        cur_dp   = disp_dp_q[k];
        cur_supp = blank_lz && zero_run && (k != 0);
      end
    end
  end

  bcd_to_seg7 u_bcd_to_seg7 (
    .bcd (cur_dig),
    .seg (enc)
  );

  always_comb begin
    seg_raw     = cur_supp ? SEG_BLANK : enc;
    an_raw      = (pre_q == '0) ? '0 : (NUM_DIGITS'(1) << idx_q);
    seg_d       = seg_raw ^ {7{SEG_INV}};
    dp_d        = (cur_dp && !cur_supp) ^ SEG_INV;
    anode_d     = an_raw ^ {NUM_DIGITS{ANODE_INV}};
    digit_idx_d = idx_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q       <= '0;
      idx_q       <= '0;
      disp_dig_q  <= '0;
      disp_dp_q   <= '0;
      pend_dig_q  <= '0;
      pend_dp_q   <= '0;
      pend_flag_q <= 1'b0;
      seg_q       <= {7{SEG_INV}};
      dp_q        <= SEG_INV;
      anode_q     <= {NUM_DIGITS{ANODE_INV}};
      digit_idx_q <= '0;
    end else begin
      pre_q       <= pre_d;
      idx_q       <= idx_d;
      disp_dig_q  <= disp_dig_d;
      disp_dp_q   <= disp_dp_d;
      pend_dig_q  <= pend_dig_d;
      pend_dp_q   <= pend_dp_d;
      pend_flag_q <= pend_flag_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      anode_q     <= anode_d;
      digit_idx_q <= digit_idx_d;
    end
  end

  assign seg       = seg_q;
  assign dp        = dp_q;
  assign anode     = anode_q;
  assign digit_idx = digit_idx_q;

endmodule
